// File: rtl/pc_branch_unit_pkg.sv
// Shared CPU package: branch FSM state encoding, datapath widths and the
// branch-offset sign-extension helper used by the PC / branch unit.
package pc_branch_unit_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned BR_OFFSET_W = 19;
    localparam int unsigned SETTLE_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EVAL   = 2'd2,
        DONE   = 2'd3
    } br_state_e;

    // Sign-extend the instruction C-field displacement to PC width.
    function automatic logic [PC_W-1:0] sext_offset(input logic [BR_OFFSET_W-1:0] off);
        return {{(PC_W - BR_OFFSET_W){off[BR_OFFSET_W-1]}}, off};
    endfunction

endpackage

// File: rtl/pc_settle_counter.sv
// Settle-delay down-counter for the branch unit.
// Ports:
//   clock, clear      : clock and synchronous active-high reset
//   load, load_value  : load the counter (takes priority over dec)
//   dec               : decrement by one, saturating at zero
//   is_last_c         : combinational terminal flag, high when count is 1
module pc_settle_counter
    import pc_branch_unit_pkg::*;
#(
    parameter int unsigned W = SETTLE_W
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         is_last_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins, decrement never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_last_c = (count_q == W'(1));

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with a conditional-branch evaluation FSM.
// Ports:
//   clock, clear  : clock and synchronous active-high reset
//   busMuxOut     : jump target from the data bus
//   brOffset      : signed branch displacement (captured on brStart)
//   incPC         : fetch strobe, PC + 1 (only while idle)
//   jump          : load PC from busMuxOut, aborting any evaluation
//   brStart       : start a conditional-branch evaluation (only while idle)
//   conditionMet  : branch condition flag, sampled once in EVAL
//   PC            : program counter
//   brBusy        : FSM not idle
//   brDone        : one-cycle pulse when an evaluation completes
//   brTaken       : result of the last completed evaluation
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned     SETTLE_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [PC_W-1:0]        busMuxOut,
    input  logic [BR_OFFSET_W-1:0] brOffset,
    input  logic                   incPC,
    input  logic                   jump,
    input  logic                   brStart,
    input  logic                   conditionMet,
    output logic [PC_W-1:0]        PC,
    output logic                   brBusy,
    output logic                   brDone,
    output logic                   brTaken
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    br_state_e              state_q,  state_d;
    logic [PC_W-1:0]        pc_q,     pc_d;
    logic [BR_OFFSET_W-1:0] offset_q, offset_d;
    logic                   taken_q,  taken_d;
    logic                   done_q,   done_d;
    logic                   busy_q,   busy_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_last;

    pc_settle_counter #(
        .W (SETTLE_W)
    ) u_settle (
        .clock      (clock),
        .clear      (clear),
        .load       (cnt_load),
        .load_value (SETTLE_LOAD),
        .dec        (cnt_dec),
        .is_last_c  (cnt_last)
    );

    // Next-state and datapath; jump overrides everything except clear.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        offset_d = offset_q;
        taken_d  = taken_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (incPC) begin
                    pc_d = pc_q + PC_W'(1);
                end
                if (brStart) begin
                    offset_d = brOffset;
                    cnt_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                // Offset is relative to the PC held at EVAL; add wraps mod 2^32.
                if (conditionMet) begin
                    pc_d = pc_q + sext_offset(offset_q);
                end
                taken_d = conditionMet;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (jump) begin
            pc_d     = busMuxOut;
            state_d  = IDLE;
            offset_d = offset_q;
            taken_d  = taken_q;
            cnt_load = 1'b0;
        end

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            offset_q <= '0;
            taken_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            offset_q <= offset_d;
            taken_q  <= taken_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign PC      = pc_q;
    assign brBusy  = busy_q;
    assign brDone  = done_q;
    assign brTaken = taken_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: two instances (settle 1 and settle 4) share one
// stimulus stream and are checked every cycle against a cycle-age model.
module tb_pc_branch_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        jump;
    logic        incPC;
    logic        brStart;
    logic        conditionMet;
    logic [31:0] busMuxOut;
    logic [18:0] brOffset;

    logic [31:0] pc_o    [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic        taken_o [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pc_branch_unit #(.RESET_PC(32'h0000_0000), .SETTLE_CYCLES(1)) dut1 (
        .clock(clock), .clear(clear), .busMuxOut(busMuxOut), .brOffset(brOffset),
        .incPC(incPC), .jump(jump), .brStart(brStart), .conditionMet(conditionMet),
        .PC(pc_o[0]), .brBusy(busy_o[0]), .brDone(done_o[0]), .brTaken(taken_o[0])
    );

    pc_branch_unit #(.RESET_PC(32'h0000_0000), .SETTLE_CYCLES(4)) dut4 (
        .clock(clock), .clear(clear), .busMuxOut(busMuxOut), .brOffset(brOffset),
        .incPC(incPC), .jump(jump), .brStart(brStart), .conditionMet(conditionMet),
        .PC(pc_o[1]), .brBusy(busy_o[1]), .brDone(done_o[1]), .brTaken(taken_o[1])
    );

    // Model: age = cycles since a branch started (0 = idle).
    // Ages 1..S settle, S+1 evaluates, S+2 is the done cycle.
    logic [31:0] m_pc    [2];
    int          m_age   [2];
    bit          m_taken [2];
    logic [18:0] m_off   [2];

    function automatic int s_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] off_val(input logic [18:0] o);
        int v;
        v = int'(o);
        if (o[18]) v = v - (1 << 19);
        return 32'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                m_pc[i] = 32'h0; m_age[i] = 0; m_taken[i] = 1'b0; m_off[i] = 19'h0;
            end else if (jump) begin
                m_pc[i] = busMuxOut; m_age[i] = 0;
            end else if (m_age[i] == 0) begin
                if (incPC) m_pc[i] = m_pc[i] + 32'd1;
                if (brStart) begin m_age[i] = 1; m_off[i] = brOffset; end
            end else if (m_age[i] <= s_of(i)) begin
                m_age[i] = m_age[i] + 1;
            end else if (m_age[i] == s_of(i) + 1) begin
                if (conditionMet) begin
                    m_pc[i] = m_pc[i] + off_val(m_off[i]);
                    m_taken[i] = 1'b1;
                end else begin
                    m_taken[i] = 1'b0;
                end
                m_age[i] = m_age[i] + 1;
            end else begin
                m_age[i] = 0;
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("pc[%0d]", i),    pc_o[i], m_pc[i]);
            check($sformatf("busy[%0d]", i),  32'(busy_o[i]),  32'(m_age[i] != 0));
            check($sformatf("done[%0d]", i),  32'(done_o[i]),  32'(m_age[i] == s_of(i) + 2));
            check($sformatf("taken[%0d]", i), 32'(taken_o[i]), 32'(m_taken[i]));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_pc(input logic [31:0] val);
        jump = 1'b1; busMuxOut = val;
        step();
        jump = 1'b0;
    endtask

    task automatic run_branch(input int inst, input logic [18:0] off, input bit cm, output int lat);
        brOffset = off; conditionMet = cm; brStart = 1'b1;
        step();
        brStart = 1'b0;
        lat = 1;
        while (!done_o[inst] && lat < 40) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        clear = 1'b1; jump = 1'b0; incPC = 1'b0; brStart = 1'b0; conditionMet = 1'b0;
        busMuxOut = 32'h0; brOffset = 19'h0;
        step(); step();
        check("rst_pc", pc_o[0], 32'h0);
        check("rst_busy", 32'(busy_o[0]), 32'h0);
        check("rst_done", 32'(done_o[0]), 32'h0);
        check("rst_taken", 32'(taken_o[1]), 32'h0);
        clear = 1'b0;

        incPC = 1'b1;
        step(); step(); step();
        incPC = 1'b0;
        check("inc3_pc", pc_o[0], 32'h0000_0003);
        check("inc3_busy", 32'(busy_o[0]), 32'h0);

        load_pc(32'h0000_0010);
        run_branch(0, 19'h00005, 1'b1, lat);
        check("fwd_lat", 32'(lat), 32'd3);
        check("fwd_pc", pc_o[0], 32'h0000_0015);
        check("fwd_taken", 32'(taken_o[0]), 32'h1);

        load_pc(32'h0000_0010);
        run_branch(0, 19'h7FFFC, 1'b0, lat);
        check("nt_lat", 32'(lat), 32'd3);
        check("nt_pc", pc_o[0], 32'h0000_0010);
        check("nt_taken", 32'(taken_o[0]), 32'h0);
        load_pc(32'h0000_0010);
        run_branch(0, 19'h7FFFC, 1'b1, lat);
        check("back_pc", pc_o[0], 32'h0000_000C);
        check("back_taken", 32'(taken_o[0]), 32'h1);

        load_pc(32'hFFFF_FFFF);
        incPC = 1'b1;
        step();
        incPC = 1'b0;
        check("wrap_pc", pc_o[0], 32'h0000_0000);

        load_pc(32'h0000_0000);
        brOffset = 19'h00005; brStart = 1'b1;
        step();
        brStart = 1'b0;
        check("abort_busy_pre", 32'(busy_o[0]), 32'h1);
        jump = 1'b1; busMuxOut = 32'h0000_0100;
        step();
        jump = 1'b0;
        check("abort_pc", pc_o[0], 32'h0000_0100);
        check("abort_busy", 32'(busy_o[0]), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check("abort_nodone", 32'(done_o[0]), 32'h0);
            step();
        end

        clear = 1'b1;
        step();
        clear = 1'b0;
        load_pc(32'h0000_0020);
        brOffset = 19'h00008; conditionMet = 1'b0; brStart = 1'b1;
        step();
        brStart = 1'b0;
        lat = 1;
        while (!done_o[1] && lat < 40) begin
            conditionMet = (lat == 5) ? 1'b1 : lat[0];
            incPC        = (lat == 2);
            brStart      = (lat == 3);
            step();
            lat++;
        end
        incPC = 1'b0; brStart = 1'b0; conditionMet = 1'b0;
        check("s4_lat", 32'(lat), 32'd6);
        check("s4_pc", pc_o[1], 32'h0000_0028);
        check("s4_taken", 32'(taken_o[1]), 32'h1);
        step();
        check("s4_idle", 32'(busy_o[1]), 32'h0);

        for (int k = 0; k < 3000; k++) begin
            clear        = ($urandom % 64) == 0;
            jump         = ($urandom % 16) == 0;
            incPC        = ($urandom % 2) == 0;
            brStart      = ($urandom % 4) == 0;
            conditionMet = ($urandom % 2) == 0;
            busMuxOut    = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + 32'($urandom % 16)) : $urandom;
            brOffset     = 19'($urandom);
            step();
        end
        clear = 1'b0; jump = 1'b0; incPC = 1'b0; brStart = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, value loaded into PC on clear.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1, legal range 1..15: cycles waited for the condition flag to settle before it is sampled.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1 bit: reset; synchronous, active-high.
REQ-005 SHALL have port busMuxOut, input, 32 bits: data bus; jump target.
REQ-006 SHALL have port brOffset, input, 19 bits: signed branch displacement (instruction C field).
REQ-007 SHALL have port incPC, input, 1 bit: fetch strobe; PC <= PC + 1.
REQ-008 SHALL have port jump, input, 1 bit: unconditional load of PC from busMuxOut.
REQ-009 SHALL have port brStart, input, 1 bit: begin conditional-branch evaluation.
REQ-010 SHALL have port conditionMet, input, 1 bit: branch condition flag from the condition flip-flop.
REQ-011 SHALL have port PC, output, 32 bits: program counter.
REQ-012 SHALL have port brBusy, output, 1 bit: high whenever FSM is not IDLE.
REQ-013 SHALL have port brDone, output, 1 bit: one-cycle pulse at end of evaluation.
REQ-014 SHALL have port brTaken, output, 1 bit: result of the last completed evaluation; holds until the next brDone or clear.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, EVAL, DONE.
REQ-016 IDLE with brStart=1 SHALL capture brOffset, load settle counter with SETTLE_CYCLES, and go to SETTLE.
REQ-017 SETTLE SHALL decrement the counter each cycle and go to EVAL in the cycle the counter reaches 1.
- SETTLE_CYCLES=1 SHALL give exactly one SETTLE cycle.
REQ-018 EVAL SHALL sample conditionMet once.
- If 1: PC <= PC + sign_extend32(captured offset), brTaken <= 1.
- If 0: PC unchanged, brTaken <= 0.
- Next state SHALL be DONE.
REQ-019 DONE SHALL assert brDone for exactly that cycle and return to IDLE.
- Latency brStart -> brDone SHALL be SETTLE_CYCLES + 2 cycles.
REQ-020 PC arithmetic SHALL be modulo 2^32.
- Increment and offset add SHALL wrap silently.
- The offset is relative to the PC value already present at EVAL.
REQ-021 Update priority, highest first: clear, jump, EVAL update, incPC.
REQ-022 jump SHALL load busMuxOut in any state.
- If the FSM is not IDLE, jump SHALL abort it to IDLE with no brDone and brTaken unchanged.
REQ-023 brStart SHALL be ignored while brBusy=1.
REQ-024 incPC SHALL be ignored while brBusy=1.
REQ-025 brStart and incPC together in IDLE SHALL both take effect: PC increments that cycle and the branch starts.
REQ-026 conditionMet SHALL be ignored outside EVAL.

Reset
REQ-027 clear SHALL set PC=RESET_PC, state=IDLE, brBusy=0, brDone=0, brTaken=0, and clear the settle counter and captured offset to 0.
REQ-028 clear mid-evaluation SHALL discard the evaluation and produce no brDone.

Structure
REQ-029 The FSM state encoding and the offset width constant (19) SHALL live in the shared CPU package.
REQ-030 The settle counter SHALL be a sub-module pc_settle_counter (load, decrement, terminal flag).

Verification
REQ-031 Clear, then incPC for 3 cycles -> PC=0x00000003, brBusy=0.
REQ-032 PC=0x00000010, brOffset=19'h00005, conditionMet=1, brStart -> brDone 3 cycles later, PC=0x00000015, brTaken=1.
REQ-033 PC=0x00000010, brOffset=19'h7FFFC (-4), conditionMet=0 -> PC stays 0x00000010, brTaken=0; repeat with conditionMet=1 -> PC=0x0000000C.
REQ-034 PC=0xFFFFFFFF, incPC -> PC=0x00000000.
REQ-035 brStart, then jump with busMuxOut=0x00000100 during SETTLE -> PC=0x00000100, FSM in IDLE, no brDone pulse.
REQ-036 SETTLE_CYCLES=4: conditionMet toggles during SETTLE and is 1 at EVAL -> brTaken=1, latency 6 cycles; incPC and a second brStart pulsed while busy -> no effect.
